regfile_share_ctrl: RTL and testbench

Controller that shares one single-read/single-write register file between two clients, A and B. The register file has a combinational read and a write on the clock edge. After reset the block sweeps every entry to a programmed init value. It then arbitrates write and read requests independently with round-robin, returning read data through a registered response. It sits between client pipelines and the register file instance, and is the only driver of the register file's ports.

---
 rtl/regfile_share_ctrl.sv | 92 +++++++++
 tb/tb_regfile_share_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_share_ctrl.sv
// regfile_share_ctrl: init sweep then round-robin sharing of a 1R/1W register file between clients A and B
module regfile_share_ctrl #(
  parameter int width = 32,
  parameter int n = 5,
  parameter int size = 32,
  parameter logic [width-1:0] init_val = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_WR_VALID,
  input  logic [n-1:0]     A_WR_INDEX,
  input  logic [width-1:0] A_WR_DATA,
  output logic             A_WR_READY,
  input  logic             B_WR_VALID,
  input  logic [n-1:0]     B_WR_INDEX,
  input  logic [width-1:0] B_WR_DATA,
  output logic             B_WR_READY,
  input  logic             A_RD_VALID,
  input  logic [n-1:0]     A_RD_INDEX,
  output logic             A_RD_READY,
  output logic             A_RESP_VALID,
  output logic [width-1:0] A_RESP_DATA,
  input  logic             B_RD_VALID,
  input  logic [n-1:0]     B_RD_INDEX,
  output logic             B_RD_READY,
  output logic             B_RESP_VALID,
  output logic [width-1:0] B_RESP_DATA,
  output logic [n-1:0]     RF_READ_INDEX,
  input  logic [width-1:0] RF_READ_DATA,
  output logic             RF_WRITE_EN,
  output logic [n-1:0]     RF_WRITE_INDEX,
  output logic [width-1:0] RF_WRITE_DATA,
  output logic             INIT_BUSY
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [n-1:0] cnt_q, cnt_d;
  logic wr_last_q, wr_last_d, rd_last_q, rd_last_d;
  logic a_resp_valid_q, a_resp_valid_d, b_resp_valid_q, b_resp_valid_d;
  logic [width-1:0] a_resp_data_q, a_resp_data_d, b_resp_data_q, b_resp_data_d;
  logic run, wr_a, wr_b, rd_a, rd_b;
  // last pointers: 0 = A, 1 = B; reset to B so A wins the first contention
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      wr_last_q      <= 1'b1;
      rd_last_q      <= 1'b1;
      a_resp_valid_q <= 1'b0;
      b_resp_valid_q <= 1'b0;
      a_resp_data_q  <= '0;
      b_resp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_last_q      <= wr_last_d;
      rd_last_q      <= rd_last_d;
      a_resp_valid_q <= a_resp_valid_d;
      b_resp_valid_q <= b_resp_valid_d;
      a_resp_data_q  <= a_resp_data_d;
      b_resp_data_q  <= b_resp_data_d;
    end
  end
  always_comb begin
    run            = state_q == RUN;
    wr_a           = run && A_WR_VALID && (!B_WR_VALID || wr_last_q);
    wr_b           = run && B_WR_VALID && (!A_WR_VALID || !wr_last_q);
    rd_a           = run && A_RD_VALID && (!B_RD_VALID || rd_last_q);
    rd_b           = run && B_RD_VALID && (!A_RD_VALID || !rd_last_q);
    state_d        = (!run && cnt_q == n'(size - 1)) ? RUN : state_q;
    cnt_d          = run ? cnt_q : cnt_q + 1'b1;
    wr_last_d      = wr_a ? 1'b0 : wr_b ? 1'b1 : wr_last_q;
    rd_last_d      = rd_a ? 1'b0 : rd_b ? 1'b1 : rd_last_q;
    a_resp_valid_d = rd_a;
    b_resp_valid_d = rd_b;
    a_resp_data_d  = rd_a ? RF_READ_DATA : a_resp_data_q;
    b_resp_data_d  = rd_b ? RF_READ_DATA : b_resp_data_q;
    A_WR_READY     = wr_a;
    B_WR_READY     = wr_b;
    A_RD_READY     = rd_a;
    B_RD_READY     = rd_b;
    A_RESP_VALID   = a_resp_valid_q;
    B_RESP_VALID   = b_resp_valid_q;
    A_RESP_DATA    = a_resp_data_q;
    B_RESP_DATA    = b_resp_data_q;
    INIT_BUSY      = !run;
    RF_WRITE_EN    = !run || wr_a || wr_b;
    RF_WRITE_INDEX = !run ? cnt_q : wr_a ? A_WR_INDEX : wr_b ? B_WR_INDEX : '0;
    RF_WRITE_DATA  = !run ? init_val : wr_a ? A_WR_DATA : wr_b ? B_WR_DATA : '0;
    RF_READ_INDEX  = rd_a ? A_RD_INDEX : rd_b ? B_RD_INDEX : '0;
  end
endmodule

// File: tb/tb_regfile_share_ctrl.sv
// tb_regfile_share_ctrl: scenario tasks with a response scoreboard, plus a size=1 instance
module tb_regfile_share_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst1_n;
  logic a_wr_valid, b_wr_valid, a_rd_valid, b_rd_valid;
  logic [4:0] a_wr_index, b_wr_index, a_rd_index, b_rd_index;
  logic [31:0] a_wr_data, b_wr_data;
  logic a_wr_ready, b_wr_ready, a_rd_ready, b_rd_ready;
  logic a_resp_valid, b_resp_valid, rf_we, init_busy;
  logic [31:0] a_resp_data, b_resp_data, rf_rd, rf_wd;
  logic [4:0] rf_ri, rf_wi;
  logic [31:0] mem [32];
  logic [31:0] exp_mem [32];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] e;
  int checks, errors;
  logic s_a_wr_valid, s_b_wr_valid, s_a_rd_valid, s_b_rd_valid;
  logic s_a_wr_ready, s_b_wr_ready, s_a_rd_ready, s_b_rd_ready;
  logic s_a_resp_valid, s_b_resp_valid, s_we, s_init_busy;
  logic [0:0] s_ri, s_wi;
  logic [7:0] s_a_wr_data, s_b_wr_data, s_a_resp_data, s_b_resp_data, s_rd, s_wd, mem1;

  regfile_share_ctrl #(.width(32), .n(5), .size(32), .init_val(32'h5A)) dut (
    .CLK(clk), .RST_N(rst_n),
    .A_WR_VALID(a_wr_valid), .A_WR_INDEX(a_wr_index), .A_WR_DATA(a_wr_data), .A_WR_READY(a_wr_ready),
    .B_WR_VALID(b_wr_valid), .B_WR_INDEX(b_wr_index), .B_WR_DATA(b_wr_data), .B_WR_READY(b_wr_ready),
    .A_RD_VALID(a_rd_valid), .A_RD_INDEX(a_rd_index), .A_RD_READY(a_rd_ready),
    .A_RESP_VALID(a_resp_valid), .A_RESP_DATA(a_resp_data),
    .B_RD_VALID(b_rd_valid), .B_RD_INDEX(b_rd_index), .B_RD_READY(b_rd_ready),
    .B_RESP_VALID(b_resp_valid), .B_RESP_DATA(b_resp_data),
    .RF_READ_INDEX(rf_ri), .RF_READ_DATA(rf_rd), .RF_WRITE_EN(rf_we),
    .RF_WRITE_INDEX(rf_wi), .RF_WRITE_DATA(rf_wd), .INIT_BUSY(init_busy));

  regfile_share_ctrl #(.width(8), .n(1), .size(1), .init_val(8'h3C)) u1 (
    .CLK(clk), .RST_N(rst1_n),
    .A_WR_VALID(s_a_wr_valid), .A_WR_INDEX(1'b0), .A_WR_DATA(s_a_wr_data), .A_WR_READY(s_a_wr_ready),
    .B_WR_VALID(s_b_wr_valid), .B_WR_INDEX(1'b0), .B_WR_DATA(s_b_wr_data), .B_WR_READY(s_b_wr_ready),
    .A_RD_VALID(s_a_rd_valid), .A_RD_INDEX(1'b0), .A_RD_READY(s_a_rd_ready),
    .A_RESP_VALID(s_a_resp_valid), .A_RESP_DATA(s_a_resp_data),
    .B_RD_VALID(s_b_rd_valid), .B_RD_INDEX(1'b0), .B_RD_READY(s_b_rd_ready),
    .B_RESP_VALID(s_b_resp_valid), .B_RESP_DATA(s_b_resp_data),
    .RF_READ_INDEX(s_ri), .RF_READ_DATA(s_rd), .RF_WRITE_EN(s_we),
    .RF_WRITE_INDEX(s_wi), .RF_WRITE_DATA(s_wd), .INIT_BUSY(s_init_busy));

  always @(posedge clk) if (rf_we) mem[rf_wi] <= rf_wd;
  assign rf_rd = mem[rf_ri];
  always @(posedge clk) if (s_we) mem1 <= s_wd;
  assign s_rd = mem1;

  always @(negedge clk) begin
    if (a_resp_valid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_resp unexpected valid data=%h", a_resp_data);
      end else begin
        e = qa.pop_front();
        if (a_resp_data !== e) begin
          errors++;
          $display("FAIL a_resp data got=%h exp=%h", a_resp_data, e);
        end
      end
    end
    if (b_resp_valid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_resp unexpected valid data=%h", b_resp_data);
      end else begin
        e = qb.pop_front();
        if (b_resp_data !== e) begin
          errors++;
          $display("FAIL b_resp data got=%h exp=%h", b_resp_data, e);
        end
      end
    end
  end

  task automatic test_reset(input int abort);
    rst_n = 1'b0;
    a_wr_valid = 0; b_wr_valid = 0; a_rd_valid = 0; b_rd_valid = 0;
    a_wr_index = 0; b_wr_index = 0; a_rd_index = 0; b_rd_index = 0;
    @(negedge clk); #1;
    checks++;
    if (init_busy !== 1'b1 || a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 ||
        a_resp_data !== 32'h0 || b_resp_data !== 32'h0 || rf_wi !== 5'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b av=%b bv=%b ad=%h bd=%h wi=%0d exp 1 0 0 0 0 0",
               init_busy, a_resp_valid, b_resp_valid, a_resp_data, b_resp_data, rf_wi);
    end
    rst_n = 1'b1;
    a_wr_valid = 1; b_rd_valid = 1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (init_busy !== 1'b1 || rf_we !== 1'b1 || rf_wi !== 5'(i) || rf_wd !== 32'h5A ||
          a_wr_ready !== 1'b0 || b_rd_ready !== 1'b0 || rf_ri !== 5'd0) begin
        errors++;
        $display("FAIL sweep cyc=%0d busy=%b we=%b wi=%0d wd=%h rdy=%b%b ri=%0d exp 1 1 %0d 5a 00 0",
                 i, init_busy, rf_we, rf_wi, rf_wd, a_wr_ready, b_rd_ready, rf_ri, i);
      end
      if (i == abort) begin
        rst_n = 1'b0; #1;
        checks++;
        if (rf_wi !== 5'd0 || init_busy !== 1'b1) begin
          errors++;
          $display("FAIL sweep_abort wi=%0d busy=%b exp 0 1", rf_wi, init_busy);
        end
        rst_n = 1'b1;
        i = 0;
        abort = -1;
      end
      @(negedge clk); #1;
    end
    checks++;
    if (init_busy !== 1'b0 || a_wr_ready !== 1'b1 || b_rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry busy=%b awr=%b brd=%b exp 0 1 1", init_busy, a_wr_ready, b_rd_ready);
    end
    a_wr_valid = 0; b_rd_valid = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h5A;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    a_wr_valid = 1; a_wr_index = 5'd3; a_wr_data = 32'h11; #1;
    checks++;
    if (a_wr_ready !== 1'b1 || b_wr_ready !== 1'b0 || rf_we !== 1'b1 || rf_wi !== 5'd3 || rf_wd !== 32'h11) begin
      errors++;
      $display("FAIL a_write rdy=%b brdy=%b we=%b wi=%0d wd=%h exp 1 0 1 3 11",
               a_wr_ready, b_wr_ready, rf_we, rf_wi, rf_wd);
    end
    exp_mem[3] = 32'h11;
    @(negedge clk);
    a_wr_valid = 0; a_rd_valid = 1; a_rd_index = 5'd3; #1;
    checks++;
    if (a_rd_ready !== 1'b1 || rf_ri !== 5'd3 || rf_we !== 1'b0 || rf_wi !== 5'd0 || rf_wd !== 32'h0) begin
      errors++;
      $display("FAIL a_read_grant rdy=%b ri=%0d we=%b wi=%0d wd=%h exp 1 3 0 0 0",
               a_rd_ready, rf_ri, rf_we, rf_wi, rf_wd);
    end
    qa.push_back(exp_mem[3]);
    @(negedge clk);
    a_rd_valid = 0; #1;
    checks++;
    if (a_resp_valid !== 1'b1 || rf_ri !== 5'd0 || a_rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL a_read_latency valid=%b ri=%0d rdy=%b exp 1 0 0", a_resp_valid, rf_ri, a_rd_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (a_resp_valid !== 1'b0 || a_resp_data !== 32'h11) begin
      errors++;
      $display("FAIL a_resp_hold valid=%b data=%h exp 0 11", a_resp_valid, a_resp_data);
    end
    b_wr_valid = 1; b_wr_index = 5'd7; b_wr_data = 32'h99; #1;
    checks++;
    if (b_wr_ready !== 1'b1 || a_wr_ready !== 1'b0 || rf_wi !== 5'd7 || rf_wd !== 32'h99) begin
      errors++;
      $display("FAIL b_write rdy=%b ardy=%b wi=%0d wd=%h exp 1 0 7 99", b_wr_ready, a_wr_ready, rf_wi, rf_wd);
    end
    exp_mem[7] = 32'h99;
    @(negedge clk);
    b_wr_valid = 0;
  endtask

  task automatic test_contention();
    logic ea;
    @(negedge clk);
    a_wr_valid = 1; a_wr_index = 5'd1; a_wr_data = 32'hA1;
    b_wr_valid = 1; b_wr_index = 5'd2; b_wr_data = 32'hB2;
    for (int k = 0; k < 4; k++) begin
      #1;
      ea = (k % 2) == 0;
      checks++;
      if (a_wr_ready !== ea || b_wr_ready !== !ea || rf_wi !== (ea ? 5'd1 : 5'd2) ||
          rf_wd !== (ea ? 32'hA1 : 32'hB2)) begin
        errors++;
        $display("FAIL wr_round_robin k=%0d ardy=%b brdy=%b wi=%0d wd=%h exp_a=%b",
                 k, a_wr_ready, b_wr_ready, rf_wi, rf_wd, ea);
      end
      @(negedge clk);
    end
    a_wr_valid = 0; b_wr_valid = 0;
    exp_mem[1] = 32'hA1;
    exp_mem[2] = 32'hB2;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    a_wr_valid = 1; a_wr_index = 5'd5; a_wr_data = 32'h77;
    b_rd_valid = 1; b_rd_index = 5'd5; #1;
    checks++;
    if (a_wr_ready !== 1'b1 || b_rd_ready !== 1'b1 || rf_ri !== 5'd5 || rf_wi !== 5'd5) begin
      errors++;
      $display("FAIL same_cycle_grant awr=%b brd=%b ri=%0d wi=%0d exp 1 1 5 5",
               a_wr_ready, b_rd_ready, rf_ri, rf_wi);
    end
    qb.push_back(exp_mem[5]);
    exp_mem[5] = 32'h77;
    @(negedge clk);
    a_wr_valid = 0; #1;
    checks++;
    if (b_rd_ready !== 1'b1 || rf_ri !== 5'd5) begin
      errors++;
      $display("FAIL reread_grant brd=%b ri=%0d exp 1 5", b_rd_ready, rf_ri);
    end
    qb.push_back(exp_mem[5]);
    @(negedge clk);
    b_rd_valid = 0;
  endtask

  task automatic test_back_to_back();
    logic ea;
    @(negedge clk);
    a_rd_valid = 1; a_rd_index = 5'd1;
    b_rd_valid = 1; b_rd_index = 5'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      ea = (k % 2) == 0;
      checks++;
      if (a_rd_ready !== ea || b_rd_ready !== !ea || rf_ri !== (ea ? 5'd1 : 5'd2)) begin
        errors++;
        $display("FAIL rd_round_robin k=%0d ardy=%b brdy=%b ri=%0d exp_a=%b", k, a_rd_ready, b_rd_ready, rf_ri, ea);
      end
      if (ea) qa.push_back(exp_mem[1]);
      else qb.push_back(exp_mem[2]);
      @(negedge clk);
    end
    a_rd_valid = 0; b_rd_valid = 0;
  endtask

  task automatic test_reset_mid();
    test_reset(10);
    @(negedge clk);
    a_rd_valid = 1; a_rd_index = 5'd3;
    @(posedge clk); #1;
    a_rd_valid = 0;
    checks++;
    if (a_resp_valid !== 1'b1 || a_resp_data !== 32'h5A) begin
      errors++;
      $display("FAIL pending_resp valid=%b data=%h exp 1 5a", a_resp_valid, a_resp_data);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (a_resp_valid !== 1'b0 || a_resp_data !== 32'h0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL resp_abort valid=%b data=%h busy=%b exp 0 0 1", a_resp_valid, a_resp_data, init_busy);
    end
    test_reset(-1);
  endtask

  task automatic test_size1();
    s_a_wr_valid = 0; s_b_wr_valid = 0; s_a_rd_valid = 0; s_b_rd_valid = 0;
    s_a_wr_data = 8'h00; s_b_wr_data = 8'h00;
    rst1_n = 1'b0;
    @(negedge clk); #1;
    rst1_n = 1'b1;
    s_a_wr_valid = 1; #1;
    checks++;
    if (s_init_busy !== 1'b1 || s_we !== 1'b1 || s_wi !== 1'b0 || s_wd !== 8'h3C || s_a_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL s1_init busy=%b we=%b wi=%b wd=%h rdy=%b exp 1 1 0 3c 0",
               s_init_busy, s_we, s_wi, s_wd, s_a_wr_ready);
    end
    s_a_wr_valid = 0;
    @(negedge clk);
    s_a_rd_valid = 1; #1;
    checks++;
    if (s_init_busy !== 1'b0 || s_a_rd_ready !== 1'b1 || s_ri !== 1'b0 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL s1_run busy=%b rdy=%b ri=%b we=%b exp 0 1 0 0", s_init_busy, s_a_rd_ready, s_ri, s_we);
    end
    @(negedge clk);
    s_a_rd_valid = 0; s_b_wr_valid = 1; s_b_wr_data = 8'h42; #1;
    checks++;
    if (s_a_resp_valid !== 1'b1 || s_a_resp_data !== 8'h3C || s_b_wr_ready !== 1'b1 || s_wi !== 1'b0 || s_wd !== 8'h42) begin
      errors++;
      $display("FAIL s1_resp_write av=%b ad=%h brdy=%b wi=%b wd=%h exp 1 3c 1 0 42",
               s_a_resp_valid, s_a_resp_data, s_b_wr_ready, s_wi, s_wd);
    end
    @(negedge clk);
    s_b_wr_valid = 0; s_b_rd_valid = 1; #1;
    checks++;
    if (s_b_rd_ready !== 1'b1 || s_a_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL s1_b_read brdy=%b av=%b exp 1 0", s_b_rd_ready, s_a_resp_valid);
    end
    @(negedge clk);
    s_b_rd_valid = 0; #1;
    checks++;
    if (s_b_resp_valid !== 1'b1 || s_b_resp_data !== 8'h42) begin
      errors++;
      $display("FAIL s1_b_resp valid=%b data=%h exp 1 42", s_b_resp_valid, s_b_resp_data);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b1; rst1_n = 1'b1;
    a_wr_data = 0; b_wr_data = 0;
    s_a_wr_valid = 0; s_b_wr_valid = 0; s_a_rd_valid = 0; s_b_rd_valid = 0;
    s_a_wr_data = 0; s_b_wr_data = 0;
    #1;
    test_reset(-1);
    test_write_read();
    test_contention();
    test_same_cycle();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid();
    test_size1();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL missing_resp pending_a=%0d pending_b=%0d exp 0 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
